// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory/IO interface: FSM encoding,
// device register addresses, data width and the timeout fill word.
package lc3_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_DEV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_W-1:0] KBSR_A    = 16'hFE00;
  localparam logic [DATA_W-1:0] KBDR_A    = 16'hFE02;
  localparam logic [DATA_W-1:0] DSR_A     = 16'hFE04;
  localparam logic [DATA_W-1:0] DDR_A     = 16'hFE06;
  localparam logic [DATA_W-1:0] DEAD_FILL = 16'hDEAD;

endpackage

// File: rtl/lc3_io_regs.sv
// Memory-mapped keyboard/display registers with their external handshakes,
// accessed through one-cycle device read/write strobes.
module lc3_io_regs
  import lc3_pkg::*;
#(
  parameter logic [DATA_W-1:0] KBSR_ADDR = KBSR_A,
  parameter logic [DATA_W-1:0] KBDR_ADDR = KBDR_A,
  parameter logic [DATA_W-1:0] DSR_ADDR  = DSR_A,
  parameter logic [DATA_W-1:0] DDR_ADDR  = DDR_A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic              dev_rd,
  input  logic              dev_wr,
  input  logic [7:0]        wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [7:0]        kb_data,
  input  logic              kb_strobe,
  output logic [7:0]        dsp_data,
  output logic              dsp_valid,
  input  logic              dsp_ready
);

  logic       kbsr_rdy;
  logic [7:0] kbdr;

  // A new keystroke outranks the clear caused by reading KBDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbsr_rdy <= 1'b0;
      kbdr     <= '0;
    end else if (kb_strobe) begin
      kbsr_rdy <= 1'b1;
      kbdr     <= kb_data;
    end else if (dev_rd && addr == KBDR_ADDR) begin
      kbsr_rdy <= 1'b0;
    end
  end

  // A DDR write outranks the consumer handshake, so the new character stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_valid <= 1'b0;
      dsp_data  <= '0;
    end else if (dev_wr && addr == DDR_ADDR) begin
      dsp_valid <= 1'b1;
      dsp_data  <= wdata;
    end else if (dsp_valid && dsp_ready) begin
      dsp_valid <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == KBSR_ADDR)      rdata = {kbsr_rdy, 15'b0};
    else if (addr == KBDR_ADDR) rdata = {8'b0, kbdr};
    else if (addr == DSR_ADDR)  rdata = {~dsp_valid, 15'b0};
    else if (addr == DDR_ADDR)  rdata = {8'b0, dsp_data};
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR owner: sequences each MIO.EN access to SRAM (req/ack with
// timeout) or to the device registers, and pulses R on completion.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int                TIMEOUT   = 64,
  parameter logic [DATA_W-1:0] KBSR_ADDR = KBSR_A,
  parameter logic [DATA_W-1:0] KBDR_ADDR = KBDR_A,
  parameter logic [DATA_W-1:0] DSR_ADDR  = DSR_A,
  parameter logic [DATA_W-1:0] DDR_ADDR  = DDR_A
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [DATA_W-1:0] mar,
  output logic [DATA_W-1:0] mdr,
  output logic              r,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [7:0]        kb_data,
  input  logic              kb_strobe,
  output logic [7:0]        dsp_data,
  output logic              dsp_valid,
  input  logic              dsp_ready
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [1:0]        state;
  logic              wr;
  logic [CNT_W-1:0]  cnt;
  logic              is_dev;
  logic              timeout;
  logic [DATA_W-1:0] dev_rdata;

  assign is_dev  = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                   (mar == DSR_ADDR)  || (mar == DDR_ADDR);
  assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

  assign r         = (state == S_DONE);
  assign mem_req   = (state == S_MEM);
  assign mem_we    = mem_req && wr;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;

  // mio_en is only looked at in IDLE, so DONE always returns through IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wr    <= 1'b0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (mio_en) begin
            wr    <= r_w;
            state <= is_dev ? S_DEV : S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state <= S_DONE;
          end else if (timeout) begin
            state <= S_DONE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DEV:   state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mar <= '0;
    else if (ld_mar) mar <= bus;
  end

  // The bus may only load MDR while no access owns it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdr <= '0;
    end else if (state == S_MEM) begin
      if (!wr && mem_ack)      mdr <= mem_rdata;
      else if (!wr && timeout) mdr <= DEAD_FILL;
    end else if (state == S_DEV) begin
      if (!wr) mdr <= dev_rdata;
    end else if (ld_mdr && !mio_en) begin
      mdr <= bus;
    end
  end

  lc3_io_regs #(
    .KBSR_ADDR (KBSR_ADDR),
    .KBDR_ADDR (KBDR_ADDR),
    .DSR_ADDR  (DSR_ADDR),
    .DDR_ADDR  (DDR_ADDR)
  ) u_io_regs (
    .clk       (clk),
    .reset     (reset),
    .addr      (mar),
    .dev_rd    ((state == S_DEV) && !wr),
    .dev_wr    ((state == S_DEV) && wr),
    .wdata     (mdr[7:0]),
    .rdata     (dev_rdata),
    .kb_data   (kb_data),
    .kb_strobe (kb_strobe),
    .dsp_data  (dsp_data),
    .dsp_valid (dsp_valid),
    .dsp_ready (dsp_ready)
  );

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Memory/IO interface unit between the LC-3 datapath and external memory.
- Owns MAR and MDR and runs each MIO.EN access through a req/ack handshake with external SRAM, or through the memory-mapped keyboard/display registers.
- Generates the R (ready) input of the microsequencer. The microsequencer spins in its wait states until R is seen.

Parameters:
- TIMEOUT, 64, max cycles to wait for mem_ack before forcing completion (≥2).
- KBSR_ADDR, 16'hFE00, keyboard status register address.
- KBDR_ADDR, 16'hFE02, keyboard data register address.
- DSR_ADDR, 16'hFE04, display status register address.
- DDR_ADDR, 16'hFE06, display data register address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus  in  16  processor bus value.
- ld_mar  in  1  load MAR from bus.
- ld_mdr  in  1  load MDR from bus (only honoured when mio_en=0).
- mio_en  in  1  request memory/IO access at address MAR.
- r_w  in  1  1=write MDR to MAR, 0=read; sampled at access start.
- mar  out  16  memory address register.
- mdr  out  16  memory data register.
- r  out  1  access complete, one-cycle pulse.
- err  out  1  sticky timeout flag; cleared only by reset.
- mem_req  out  1  external access request.
- mem_we  out  1  external write enable, valid with mem_req.
- mem_addr  out  16  external address (=MAR).
- mem_wdata  out  16  external write data (=MDR).
- mem_rdata  in  16  external read data, valid with mem_ack.
- mem_ack  in  1  external completion.
- kb_data  in  8  keyboard character.
- kb_strobe  in  1  one-cycle pulse: new character.
- dsp_data  out  8  display character.
- dsp_valid  out  1  display character pending.
- dsp_ready  in  1  display consumes on valid&&ready.

Behaviour:
- Reset values: mar=0, mdr=0, r=0, err=0, mem_req=0, mem_we=0, dsp_valid=0, dsp_data=0, KBSR=0, KBDR=0. FSM state is IDLE.
- Reset mid-access: mem_req drops immediately. There is no completion pulse.
- MAR loads from bus on ld_mar in any state.
- MDR loads from bus on ld_mdr && !mio_en in IDLE or DONE.
- FSM states: IDLE, MEM, DEV, DONE.
- IDLE with mio_en=1: latch r_w into wr.
  - If MAR matches one of the four device addresses, go to DEV.
  - Otherwise go to MEM.
  - Any other address in xFE00–xFFFF goes to MEM.
- MEM:
  - mem_req=1, mem_we=wr. Outputs are held stable until ack.
  - On mem_ack: if read, mdr<=mem_rdata. Then go to DONE.
  - If wait count reaches TIMEOUT without ack: read sets mdr<=16'hDEAD, err<=1, go to DONE.
- DEV (one cycle), then go to DONE:
  - Read KBSR: mdr={KBSR[15],15'b0}.
  - Read KBDR: mdr={8'b0,KBDR}. KBSR[15] clears.
  - Read DSR: mdr={!dsp_valid,15'b0}.
  - Write DDR: dsp_data<=mdr[7:0], dsp_valid<=1. If dsp_valid is already 1, the old character is overwritten.
  - Writes to KBSR, KBDR or DSR are ignored.
- DONE: r=1 for exactly this cycle, then return to IDLE.
  - mio_en is not sampled in DONE. Back-to-back accesses are separated by at least one IDLE cycle.
- Read latency:
  - Device access: R asserts 2 cycles after the mio_en-sampling edge.
  - Memory access: R asserts 1 cycle after the ack edge.
- Keyboard: kb_strobe sets KBSR[15]=1 and KBDR<=kb_data. If kb_strobe coincides with a KBDR read, the strobe wins: KBSR[15] stays 1 and the new data is stored.
- Display: dsp_valid clears on dsp_valid && dsp_ready. If a DDR write coincides with a handshake, dsp_valid stays 1 with the new data.
- mem_ack outside MEM is ignored.

Decomposition:
- Shared package lc3_pkg holds:
  - FSM state encoding.
  - Device address constants.
  - 16'hDEAD fill value.
  - Word width constant 16.
- One natural sub-module, lc3_io_regs: KBSR/KBDR/DSR/DDR plus the keyboard and display handshakes, with a device read/write strobe interface.
- The FSM, MAR/MDR and the timeout counter stay in the top module.

Test Plan:
- Reset, then mio_en=1 with mar=16'h3000, r_w=0, mem_ack returned 3 cycles after mem_req with rdata=16'h1234 → mem_req high 3 cycles, r pulses once, mdr=16'h1234, err=0.
- Write: mar=16'h4000, mdr=16'hBEEF, r_w=1 → mem_we=1, mem_wdata=16'hBEEF held until ack; mdr unchanged after r.
- kb_strobe with kb_data=8'h41, then read KBSR → mdr=16'h8000. Then read KBDR → mdr=16'h0041, and a following KBSR read gives 16'h0000.
- Write DDR with mdr=16'h0058 while dsp_ready=0 → dsp_valid=1, dsp_data=8'h58, DSR read=16'h0000. Raise dsp_ready → dsp_valid=0, DSR read=16'h8000.
- Read with no mem_ack → r after TIMEOUT cycles, mdr=16'hDEAD, err=1 and stays set through later accesses.
- Assert reset while in MEM → mem_req=0 immediately, r never pulses, mar=0, and the next access proceeds normally.
